// File: rtl/skewer.sv
// Skews unskewed rows into a diagonal wavefront for the systolic mesh edge.
// Optional macro SKEWER_BUBBLE_EN: keep stepping with bubbles while a tile is starved.

module skewer_lane #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  flag_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  flag_o
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] dat_q;
    logic [DEPTH-1:0]                 flg_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dat_q <= '0;
            flg_q <= '0;
        end else if (step_i) begin
            dat_q[0] <= data_i;
            flg_q[0] <= flag_i;
            for (int k = 1; k < DEPTH; k++) begin
                dat_q[k] <= dat_q[k-1];
                flg_q[k] <= flg_q[k-1];
            end
        end
    end

    assign data_o = dat_q[DEPTH-1];
    assign flag_o = flg_q[DEPTH-1];
endmodule

module skewer #(
    parameter int MESH_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic                                  in_last_i,
    input  logic [MESH_WIDTH-1:0][DATA_WIDTH-1:0] data_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [MESH_WIDTH-1:0][DATA_WIDTH-1:0] data_o,
    output logic [MESH_WIDTH-1:0]                 lane_valid_o,
    output logic                                  out_last_o,
    output logic                                  busy_o
);
    localparam int CW = $clog2(MESH_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept, bubble, step, feed_vld;

    assign feed_vld = in_valid_i && (state_q != DRAIN);
    assign accept   = feed_vld && out_ready_i;
`ifdef SKEWER_BUBBLE_EN
    assign bubble   = (state_q == STREAM) && !in_valid_i && out_ready_i;
`else
    assign bubble   = 1'b0;
`endif
    // Drain steps are paced only by the mesh; stream steps need a row (or a bubble).
    assign step     = accept || bubble || ((state_q == DRAIN) && out_ready_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_o  = out_ready_i;
        out_valid_o = in_valid_i || bubble;
        out_last_o  = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    if (!in_last_i) begin
                        state_d = STREAM;
                    end else if (MESH_WIDTH > 1) begin
                        state_d = DRAIN;
                        cnt_d   = CW'(MESH_WIDTH - 1);
                    end else begin
                        state_d    = IDLE;
                        out_last_o = 1'b1;
                    end
                end
            end
            DRAIN: begin
                in_ready_o  = 1'b0;
                out_valid_o = 1'b1;
                if (step) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d    = IDLE;
                        out_last_o = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane 0 is combinational; padding is forced to zero rather than passing data_i through.
    assign data_o[0]       = feed_vld ? data_i[0] : '0;
    assign lane_valid_o[0] = feed_vld;

    for (genvar i = 1; i < MESH_WIDTH; i++) begin : g_lane
        skewer_lane #(
            .DEPTH      (i),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .step_i (step),
            .data_i (feed_vld ? data_i[i] : '0),
            .flag_i (feed_vld),
            .data_o (data_o[i]),
            .flag_o (lane_valid_o[i])
        );
    end

    assign busy_o = (state_q != IDLE);
endmodule

// File: tb/tb_skewer.sv
// Scoreboarded random + directed bench for skewer; model is a history of injected columns.
module tb_skewer;
    localparam int MW = 4;
    localparam int DW = 32;

    typedef logic [MW-1:0][DW-1:0] row_t;
    typedef struct { row_t d; logic [MW-1:0] f; } col_t;
    typedef struct { row_t d; logic [MW-1:0] f; logic last; } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic          in_last_i = 1'b0;
    row_t          data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    row_t          data_o;
    logic [MW-1:0] lane_valid_o;
    logic          out_last_o;
    logic          busy_o;

    skewer #(.MESH_WIDTH(MW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_last_i(in_last_i), .data_i(data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .data_o(data_o), .lane_valid_o(lane_valid_o),
        .out_last_o(out_last_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int   checks = 0;
    int   errors = 0;
    col_t inj[$];
    exp_t expq[$];
    exp_t seen[$];
    int   pending_drain = 0;
    bit   in_tile = 0;

    task automatic check(input string name, input logic [MW*DW-1:0] act, input logic [MW*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output at step n on lane i is whatever was injected at step n-i on that lane.
    function automatic exp_t predict(input bit last);
        exp_t e;
        int n;
        n = inj.size() - 1;
        e.d = '0; e.f = '0; e.last = last;
        for (int i = 0; i < MW; i++)
            if (n - i >= 0) begin
                e.d[i] = inj[n-i].d[i];
                e.f[i] = inj[n-i].f[i];
            end
        return e;
    endfunction

    // Called just after a posedge; drives one cycle and advances the model across the next edge.
    task automatic drive(input bit v, input row_t d, input bit last, input bit ordy);
        bit   is_drain, step, bub;
        col_t c;
        in_valid_i = v; data_i = d; in_last_i = last; out_ready_i = ordy;
        is_drain = pending_drain > 0;
        bub = 0;
        step = is_drain ? ordy : (ordy && v);
`ifdef SKEWER_BUBBLE_EN
        if (!is_drain && in_tile && !v && ordy) begin step = 1; bub = 1; end
`endif
        if (step) begin
            if (is_drain || bub) begin c.d = '0; c.f = '0; end
            else begin c.d = d; c.f = '1; end
            inj.push_back(c);
            expq.push_back(predict(is_drain ? (pending_drain == 1) : (MW == 1 && last && !bub)));
        end
        @(negedge clk_i);
        check("in_ready", MW*DW'(in_ready_o), MW*DW'(is_drain ? 1'b0 : ordy));
        check("out_valid", MW*DW'(out_valid_o), MW*DW'(is_drain || v || bub));
        check("busy", MW*DW'(busy_o), MW*DW'(is_drain || in_tile));
        @(posedge clk_i); #1;
        if (step) begin
            if (is_drain) pending_drain--;
            else if (!bub) begin
                if (last) begin in_tile = 0; pending_drain = MW - 1; end
                else in_tile = 1;
            end
        end
    endtask

    task automatic do_reset(input bit ordy);
        rst_ni = 0; in_valid_i = 0; in_last_i = 0; data_i = '0; out_ready_i = ordy;
        @(posedge clk_i); #1;
        rst_ni = 1;
        inj.delete(); expq.delete();
        pending_drain = 0; in_tile = 0;
    endtask

    task automatic check_idle(input bit ordy);
        in_valid_i = 0; in_last_i = 0; data_i = '0; out_ready_i = ordy;
        @(negedge clk_i);
        check("idle_data", data_o, '0);
        check("idle_lane_valid", MW*DW'(lane_valid_o), '0);
        check("idle_busy", MW*DW'(busy_o), '0);
        check("idle_out_valid", MW*DW'(out_valid_o), '0);
        check("idle_in_ready", MW*DW'(in_ready_o), MW*DW'(ordy));
        @(posedge clk_i); #1;
    endtask

    function automatic row_t mk_row(input int k);
        row_t r;
        for (int i = 0; i < MW; i++) r[i] = DW'(16 * k + i);
        return r;
    endfunction

    task automatic check_diag(input string tag, input int nsteps);
        row_t r3, r6;
        check({tag, "_steps"}, MW*DW'(seen.size()), MW*DW'(nsteps));
        if (seen.size() == nsteps && nsteps >= 7) begin
            r3[3] = 32'h03; r3[2] = 32'h12; r3[1] = 32'h21; r3[0] = 32'h30;
            r6 = '0; r6[3] = 32'h33;
            check({tag, "_step0"}, seen[0].d, '0);
            check({tag, "_step0_lv"}, MW*DW'(seen[0].f), MW*DW'(4'b0001));
            if (nsteps == 7) begin
                check({tag, "_step3"}, seen[3].d, r3);
                check({tag, "_step3_lv"}, MW*DW'(seen[3].f), MW*DW'(4'b1111));
            end
            check({tag, "_last_data"}, seen[nsteps-1].d, r6);
            check({tag, "_last_lv"}, MW*DW'(seen[nsteps-1].f), MW*DW'(4'b1000));
            check({tag, "_last_flag"}, MW*DW'(seen[nsteps-1].last), MW*DW'(1'b1));
        end
    endtask

    // Monitor: pops the scoreboard on every DUT step and checks stall stability.
    initial begin
        exp_t e, got;
        bit   have_prev, prev_stall;
        row_t prev_d;
        logic [MW-1:0] prev_f;
        have_prev = 0; prev_stall = 0; prev_d = '0; prev_f = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin have_prev = 0; continue; end
            if (have_prev && prev_stall && out_valid_o) begin
                check("stall_data", data_o, prev_d);
                check("stall_lane_valid", MW*DW'(lane_valid_o), MW*DW'(prev_f));
            end
            if (out_valid_o && out_ready_i) begin
                got.d = data_o; got.f = lane_valid_o; got.last = out_last_o;
                seen.push_back(got);
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_step: got data %h with no step expected at %0t", data_o, $time);
                end else begin
                    e = expq.pop_front();
                    check("step_data", data_o, e.d);
                    check("step_lane_valid", MW*DW'(lane_valid_o), MW*DW'(e.f));
                    check("step_last", MW*DW'(out_last_o), MW*DW'(e.last));
                end
            end
            have_prev = 1;
            prev_stall = out_valid_o && !out_ready_i;
            prev_d = data_o; prev_f = lane_valid_o;
        end
    end

    initial begin
        row_t cur;
        bit   have, curlast, ordy;
        do_reset(1);
        check_idle(1);
        check_idle(0);

        // Back-to-back tile.
        seen.delete();
        for (int k = 0; k < 4; k++) drive(1, mk_row(k), k == 3, 1);
        for (int k = 0; k < 3; k++) drive(0, '0, 0, 1);
        check_diag("b2b", 7);

        // Mesh stall for 2 cycles at step 2.
        seen.delete();
        drive(1, mk_row(0), 0, 1);
        drive(1, mk_row(1), 0, 1);
        drive(1, mk_row(2), 0, 0);
        drive(1, mk_row(2), 0, 0);
        drive(1, mk_row(2), 0, 1);
        drive(1, mk_row(3), 1, 1);
        for (int k = 0; k < 3; k++) drive(0, '0, 0, 1);
        check_diag("stall", 7);

        // 3-cycle input gap between R1 and R2.
        seen.delete();
        drive(1, mk_row(0), 0, 1);
        drive(1, mk_row(1), 0, 1);
        for (int k = 0; k < 3; k++) drive(0, '0, 0, 1);
        drive(1, mk_row(2), 0, 1);
        drive(1, mk_row(3), 1, 1);
        for (int k = 0; k < 3; k++) drive(0, '0, 0, 1);
`ifdef SKEWER_BUBBLE_EN
        check_diag("gap", 10);
`else
        check_diag("gap", 7);
`endif

        // Single-row tile straight into drain.
        seen.delete();
        drive(1, mk_row(5), 1, 1);
        for (int k = 0; k < 3; k++) drive(0, '0, 0, 1);
        check("single_steps", MW*DW'(seen.size()), MW*DW'(4));

        // Reset during drain with two steps left.
        drive(1, mk_row(6), 1, 1);
        drive(0, '0, 0, 1);
        do_reset(1);
        check_idle(1);
        check_idle(0);
        seen.delete();
        for (int k = 0; k < 4; k++) drive(1, mk_row(k), k == 3, 1);
        for (int k = 0; k < 3; k++) drive(0, '0, 0, 1);
        check_diag("post_reset", 7);

        // Random tiles with random back-pressure.
        have = 0; curlast = 0; cur = '0;
        repeat (600) begin
            ordy = $urandom_range(0, 3) != 0;
            if (pending_drain > 0) drive(0, '0, 0, ordy);
            else begin
                if (!have && $urandom_range(0, 3) != 0) begin
                    have = 1;
                    for (int i = 0; i < MW; i++) cur[i] = $urandom;
                    curlast = $urandom_range(0, 4) == 0;
                end
                drive(have, have ? cur : '0, have ? curlast : 1'b0, ordy);
                if (have && ordy) have = 0;
            end
        end
        for (int k = 0; k < 20 && pending_drain > 0; k++) drive(0, '0, 0, 1);
        drive(0, '0, 0, 1);
        check("scoreboard_empty", MW*DW'(expq.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/skewer.md
Name: skewer

Overview:
- Feeds the systolic mesh. Accepts unskewed rows and emits them as a diagonal wavefront: lane i of each row is delayed by i steps.
- Rows arrive on a valid/ready interface. Outputs drive the mesh edge with valid/ready, so the mesh can stall the wavefront.
- After the last row of a tile, the block drains MESH_WIDTH-1 zero-padded steps so the trailing diagonal leaves completely.

Parameters:
- MESH_WIDTH, 4, number of lanes (rows/cols of the mesh); must be >= 1.
- DATA_WIDTH, 32, bits per element.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- in_valid_i  in  1  row valid.
- in_ready_o  out  1  row accepted when in_valid_i && in_ready_o.
- in_last_i  in  1  row is the final row of the tile.
- data_i  in  [MESH_WIDTH-1:0][DATA_WIDTH-1:0]  unskewed row.
- out_valid_o  out  1  data_o holds a wavefront step.
- out_ready_i  in  1  mesh consumes the step (pump).
- data_o  out  [MESH_WIDTH-1:0][DATA_WIDTH-1:0]  skewed step.
- lane_valid_o  out  [MESH_WIDTH-1:0]  per-lane flag: lane carries real data, not padding.
- out_last_o  out  1  final step of the tile.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: one clock and one reset; rst_ni is synchronous and active-low.
  - Reset clears all delay registers and lane flags to 0, sets state IDLE and drain counter 0.
  - Reset mid-tile discards all in-flight data; no partial drain follows.
- FSM states: IDLE, STREAM, DRAIN.
- step = out_valid_o && out_ready_i. All delay registers shift only on step.
- IDLE/STREAM:
  - in_ready_o = out_ready_i.
  - out_valid_o = in_valid_i.
  - Lane 0 outputs data_i[0] combinationally; lane_valid_o[0] = in_valid_i.
- DRAIN:
  - in_ready_o = 0; out_valid_o = 1.
  - Lane 0 input is zero and its flag is 0.
- Lane i>0: a chain of i registers (data plus flag), fed on step by data_i[i] and the accept flag (zero/0 in DRAIN).
  - data_o[i] = tail of the chain; lane_valid_o[i] = tail flag.
  - Zero latency on lane 0; latency of i steps on lane i.
- Transitions:
  - IDLE -> STREAM on an accept with !in_last_i.
  - IDLE/STREAM -> DRAIN on an accept with in_last_i and MESH_WIDTH > 1. The counter loads MESH_WIDTH-1.
  - DRAIN: each step decrements the counter. When a step occurs with counter == 1, go to IDLE.
  - MESH_WIDTH == 1: an accept with in_last_i goes directly to IDLE.
- out_last_o:
  - Asserted on the DRAIN step with counter == 1.
  - When MESH_WIDTH == 1, asserted on the accepting step with in_last_i.
- Stalls:
  - out_ready_i = 0 freezes everything; outputs stay stable.
  - in_valid_i = 0 in STREAM produces no step and holds the wavefront.
- Counter width: $clog2(MESH_WIDTH)+1.
- Padding values are always 0.

Optional Feature:
- Macro: SKEWER_BUBBLE_EN.
- Defined: in STREAM with in_valid_i = 0 and out_ready_i = 1, the block still asserts out_valid_o and steps with a bubble (lane 0 zero, flag 0). Earlier rows keep advancing and lane_valid_o marks the holes.
- Undefined: no bubbles are inserted; the wavefront holds until the next row arrives, as specified above.

Test Plan:
- MW=4. Rows R0..R3 back-to-back (R3 last; element Rk[i] = 16k+i), out_ready_i = 1 -> 7 steps.
  - Step 0: data_o = {0,0,0,0x00}.
  - Step 3: data_o = {0x03,0x12,0x21,0x30}.
  - Step 6: data_o = {0x33,0,0,0}, out_last_o = 1, then IDLE.
  - lane_valid_o follows the same diagonal.
- Same stream with out_ready_i low for 2 cycles at step 2 -> data_o, lane_valid_o and in_ready_o are held stable with in_ready_o = 0; the output sequence is otherwise identical.
- in_valid_i deasserted for 3 cycles between R1 and R2 (macro undefined) -> no steps, outputs held; final sequence identical to the first test.
- Same gap with SKEWER_BUBBLE_EN -> 3 extra steps with lane_valid_o showing a diagonal of zeros; total 10 steps; out_last_o on the last step.
- Single row with in_last_i = 1 from IDLE -> DRAIN for 3 steps; in_ready_o = 0 throughout DRAIN; out_last_o on the 4th step.
- rst_ni low during DRAIN (counter = 2) -> next cycle: IDLE, data_o = 0, lane_valid_o = 0, busy_o = 0, in_ready_o = out_ready_i.
